bias_read_control: RTL and testbench
====================================

# bias_read_control

Downstream neighbour of the bias FIFO control stage. Once the bias buffer banks are loaded, this block replays their contents to the PE array. It reads all BUFFER_NUM banks at one address per cycle and reassembles the X_PE 8-bit biases of that address. It emits them as one lane-aligned vector over a valid/ready handshake, sweeping `bias_num` addresses `repeat_num` times per configuration.

## Interface
- X_PE, 16: PE lanes, i.e. biases per vector.
- ADDR_LEN, 16: bias buffer address width.
- DATA_LEN, 64: width of one bank word.
- SINGLE_LEN, 24: width of the count fields.
- OUT_LEN, 16: output lane width, signed.
- BUFFER_NUM, 8*X_PE/DATA_LEN: bank count.
- clk  in  1  clock; one clock domain, all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- conf  in  1  one-cycle start pulse; samples the four config inputs below.
- bias_num  in  SINGLE_LEN  addresses per sweep.
- repeat_num  in  SINGLE_LEN  number of sweeps.
- bb_st_addr  in  ADDR_LEN  first buffer address.
- bias_shift  in  4  alignment left-shift; used only with BIAS_ALIGN_EN.
- bb_rd_en  out  1  read strobe, common to all banks.
- bb_rd_addr  out  ADDR_LEN  read address, common to all banks.
- bb_rd_data  in  BUFFER_NUM*DATA_LEN  concatenated bank words; bank b at [b*DATA_LEN +: DATA_LEN]; valid 1 cycle after bb_rd_en.
- bias_out  out  X_PE*OUT_LEN  lane l at [l*OUT_LEN +: OUT_LEN].
- bias_valid  out  1  bias_out holds a vector.
- bias_ready  in  1  consumer accepts the vector this cycle.
- done  out  1  one-cycle pulse after the last vector is accepted.
- idle  out  1  high in IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on conf, provided bias_num != 0 and repeat_num != 0.
  - Samples bb_st_addr, bias_num, repeat_num, bias_shift.
  - Clears addr_cnt, rep_cnt.
- IDLE: conf with bias_num == 0 or repeat_num == 0 -> stay in IDLE, pulse done the next cycle, issue no reads.
- conf outside IDLE is ignored.
- RUN issues one read per cycle while occupancy + pending < 3.
  - occupancy: entries in the 3-deep output FIFO.
  - pending: reads issued whose data has not yet been written into the FIFO.
  - bb_rd_addr = st_addr + addr_cnt.
  - addr_cnt wraps to 0 at bias_num-1; rep_cnt increments on each wrap.
- RUN -> DRAIN on issuing the read with addr_cnt == bias_num-1 and rep_cnt == repeat_num-1.
- DRAIN -> IDLE when FIFO and pending are both empty after the final handshake; done pulses in that same cycle.
- Lane mapping: lane l = byte (l mod (DATA_LEN/8)) of bank (l div (DATA_LEN/8)). Byte k occupies bits [8k+7:8k].
- Each lane is signed 8-bit, sign-extended to OUT_LEN.
- Address arithmetic is modulo 2^ADDR_LEN and wraps silently.
- Handshake: transfer when bias_valid && bias_ready.
  - bias_out is stable while valid && !ready.
  - bias_valid does not depend combinationally on bias_ready.
- Vector order: address-major inside each sweep, sweeps in sequence.

## Timing
- Reset values: bb_rd_en=0, bb_rd_addr=0, bias_out=0, bias_valid=0, done=0, idle=1. FIFO and counters are cleared.
- Reset mid-operation aborts immediately: no done pulse, in-flight read data is discarded.
- Latency: conf at edge 0 -> bb_rd_en high in cycle 1 -> data in cycle 2 -> bias_valid high in cycle 3.
- With bias_ready held high the block sustains 1 vector per cycle with no bubbles.
- bias_ready low: at most 3 reads are outstanding; reads resume the cycle after a pop frees a slot.
- done pulses 1 cycle after the final accepted vector.
- Total vectors per configuration = bias_num*repeat_num. The product is never formed in hardware.

## Configuration
- BIAS_ALIGN_EN defined:
  - Each sign-extended lane is arithmetically shifted left by the sampled bias_shift.
  - Result saturates to [-2^(OUT_LEN-1), 2^(OUT_LEN-1)-1].
  - The stage is combinational between FIFO output and bias_out; latency is unchanged.
- BIAS_ALIGN_EN undefined: bias_shift is ignored; lanes are plain sign extension.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE/RUN/DRAIN).
  - FIFO depth constant (3).
  - Lane-mapping helper function (lane index -> bank, byte).
- One sub-module, bias_vec_fifo: 3-entry, X_PE*8-bit synchronous FIFO with count output. Lane alignment happens after it.

## Test plan
- X_PE=16, DATA_LEN=64, bias_num=4, repeat_num=2, bb_st_addr=0x10, ready always 1.
  - Addresses 0x10..0x13 read twice; 8 vectors on consecutive cycles starting cycle 3; done at cycle 11.
- Same config, bias_ready toggling 1-0-0-1.
  - All 8 vectors in order, no duplicates or drops; bias_out stable while stalled; bb_rd_en never leaves more than 3 outstanding.
- Bank0 word byte0=0x80, bank1 byte7=0x7F.
  - Lane0 = 0xFF80 and lane15 = 0x007F without the macro.
  - With BIAS_ALIGN_EN and shift=9: lane0 = 0x8000, lane15 = 0x7FFF.
- bias_num=0 -> no bb_rd_en; done pulses 1 cycle after conf; idle stays 1.
- bb_st_addr=0xFFFE, bias_num=3 -> read addresses 0xFFFE, 0xFFFF, 0x0000.
- rst_n low for 1 cycle mid-sweep -> all outputs reach their reset values next cycle; a following conf works normally; conf pulsed while in RUN has no effect.

Source files
------------

// File: rtl/bias_read_control_pkg.sv
// bias_read_control_pkg
// Shared definitions for the bias read-out stage. These are the controller
// state encoding, the output FIFO depth, and the helper that maps a PE lane
// onto its bank and byte position.
// Optional feature macro used by the importing files: BIAS_ALIGN_EN.
package bias_read_control_pkg;

    // Controller states: waiting for a configuration, issuing reads,
    // and waiting for the last vectors to leave.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // The output FIFO has three entries. This is enough to cover the
    // one-cycle read latency plus one registered stage, so the block can
    // stream at full rate.
    localparam int FIFO_DEPTH = 3;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    // Position of one lane's byte inside the concatenated bank words.
    typedef struct packed {
        int bank;
        int byte_idx;
    } lane_loc_t;

    // Lane l lives in byte (l mod bytes-per-word) of bank (l div bytes-per-word).
    function automatic lane_loc_t lane_loc(input int lane, input int data_len);
        lane_loc_t loc;
        loc.bank     = lane / (data_len / 8);
        loc.byte_idx = lane % (data_len / 8);
        return loc;
    endfunction

endpackage

// File: rtl/bias_read_control_fifo.sv
// bias_vec_fifo
// A synchronous FIFO with three entries. It holds byte vectors that have been
// reassembled from the bias banks. The head entry can be read
// combinationally, and the module reports how many entries it holds.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   push, push_data write one vector (ignored when full and not popping)
//   pop             remove the head vector (ignored when empty)
//   head            current head vector
//   count           number of stored vectors
//   empty           no vector stored
// Optional feature macro of the enclosing design: BIAS_ALIGN_EN (unused here).
module bias_vec_fifo
    import bias_read_control_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  empty
);

    logic [WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    // The pointers wrap at the non-power-of-two depth.
    function automatic logic [FIFO_PTR_W-1:0] ptr_inc(input logic [FIFO_PTR_W-1:0] p);
        return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle. In that case the slot being written is the one being freed.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bias_read_control.sv
// bias_read_control
// This block replays the loaded bias buffer banks to the PE array. Each
// cycle it reads every bank at one common address. It then reassembles the
// X_PE signed bytes of that address into one lane-aligned vector and offers
// that vector on a valid/ready handshake. A configuration sweeps bias_num
// addresses, repeat_num times.
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   conf                       start pulse; samples bias_num, repeat_num,
//                              bb_st_addr and bias_shift
//   bb_rd_en, bb_rd_addr       common read strobe/address to all banks
//   bb_rd_data                 bank words, valid one cycle after bb_rd_en
//   bias_out, bias_valid,      output vector handshake
//   bias_ready
//   done                       one-cycle pulse when a configuration finishes
//   idle                       controller is waiting for conf
// Optional feature: define BIAS_ALIGN_EN to shift each lane left by
// bias_shift with saturation. Without it, bias_shift is ignored.
module bias_read_control
    import bias_read_control_pkg::*;
#(
    parameter int X_PE       = 16,
    parameter int ADDR_LEN   = 16,
    parameter int DATA_LEN   = 64,
    parameter int SINGLE_LEN = 24,
    parameter int OUT_LEN    = 16,
    parameter int BUFFER_NUM = 8 * X_PE / DATA_LEN
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           conf,
    input  logic [SINGLE_LEN-1:0]          bias_num,
    input  logic [SINGLE_LEN-1:0]          repeat_num,
    input  logic [ADDR_LEN-1:0]            bb_st_addr,
    input  logic [3:0]                     bias_shift,
    output logic                           bb_rd_en,
    output logic [ADDR_LEN-1:0]            bb_rd_addr,
    input  logic [BUFFER_NUM*DATA_LEN-1:0] bb_rd_data,
    output logic [X_PE*OUT_LEN-1:0]        bias_out,
    output logic                           bias_valid,
    input  logic                           bias_ready,
    output logic                           done,
    output logic                           idle
);

    localparam int VEC_W = X_PE * 8;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_LEN-1:0]     st_addr;
    logic [SINGLE_LEN-1:0]   bias_num_r;
    logic [SINGLE_LEN-1:0]   repeat_num_r;
    logic [SINGLE_LEN-1:0]   addr_cnt;
    logic [SINGLE_LEN-1:0]   rep_cnt;
    logic                    rd_pending;
    logic                    zero_done;
    logic                    cfg_ok;
    logic                    cfg_zero;
    logic                    issue;
    logic                    addr_last;
    logic                    rep_last;
    logic                    drain_done;
    logic [VEC_W-1:0]        rd_vec;
    logic [VEC_W-1:0]        fifo_head;
    logic [FIFO_CNT_W-1:0]   fifo_count;
    logic                    fifo_empty;
    logic                    pop;
    logic [X_PE*OUT_LEN-1:0] aligned;

`ifdef BIAS_ALIGN_EN
    localparam int WIDE_W = OUT_LEN + 16;
    localparam logic signed [WIDE_W-1:0] SAT_MAX = {{17{1'b0}}, {(OUT_LEN-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_MIN = {{17{1'b1}}, {(OUT_LEN-1){1'b0}}};
    logic [3:0] shift_r;
`else
    logic unused_shift;
    assign unused_shift = ^bias_shift;
`endif

    assign cfg_ok   = conf && (bias_num != '0) && (repeat_num != '0);
    assign cfg_zero = conf && ((bias_num == '0) || (repeat_num == '0));

    // Reads are throttled so that every issued read always has a FIFO slot
    // waiting for it. The slots are counted as stored entries plus the one
    // read whose data arrives next cycle.
    always_comb begin
        issue      = 1'b0;
        addr_last  = (addr_cnt == bias_num_r - SINGLE_LEN'(1));
        rep_last   = (rep_cnt == repeat_num_r - SINGLE_LEN'(1));
        drain_done = (state == ST_DRAIN) && fifo_empty && !rd_pending;
        if (state == ST_RUN) begin
            issue = (({1'b0, fifo_count} + (FIFO_CNT_W+1)'(rd_pending))
                     < (FIFO_CNT_W+1)'(FIFO_DEPTH));
        end
    end

    // Next state. A conf pulse seen outside IDLE is deliberately ignored.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cfg_ok) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && addr_last && rep_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Configuration capture and the address/sweep counters. The total number
    // of vectors is never computed. The sweep ends when both counters reach
    // their last values together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_addr      <= '0;
            bias_num_r   <= '0;
            repeat_num_r <= '0;
            addr_cnt     <= '0;
            rep_cnt      <= '0;
`ifdef BIAS_ALIGN_EN
            shift_r      <= '0;
`endif
        end else if (state == ST_IDLE) begin
            if (cfg_ok) begin
                st_addr      <= bb_st_addr;
                bias_num_r   <= bias_num;
                repeat_num_r <= repeat_num;
                addr_cnt     <= '0;
                rep_cnt      <= '0;
`ifdef BIAS_ALIGN_EN
                shift_r      <= bias_shift;
`endif
            end
        end else if (issue) begin
            if (addr_last) begin
                addr_cnt <= '0;
                rep_cnt  <= rep_cnt + 1'b1;
            end else begin
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

    // rd_pending marks that bank data for the previous read is on
    // bb_rd_data this cycle. zero_done produces the done pulse for an empty
    // configuration, which never leaves IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            zero_done  <= 1'b0;
        end else begin
            rd_pending <= issue;
            zero_done  <= (state == ST_IDLE) && cfg_zero;
        end
    end

    assign bb_rd_en   = issue;
    assign bb_rd_addr = st_addr + ADDR_LEN'(addr_cnt);
    assign done       = drain_done || zero_done;
    assign idle       = (state == ST_IDLE);

    // Gather lane bytes from their bank positions into a lane-ordered vector.
    for (genvar l = 0; l < X_PE; l++) begin : g_gather
        localparam lane_loc_t LOC     = lane_loc(l, DATA_LEN);
        localparam int        BIT_OFF = LOC.bank * DATA_LEN + LOC.byte_idx * 8;
        assign rd_vec[l*8 +: 8] = bb_rd_data[BIT_OFF +: 8];
    end

    assign pop = bias_valid && bias_ready;

    bias_vec_fifo #(
        .WIDTH (VEC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pending),
        .push_data (rd_vec),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Lane widening happens after the FIFO, so it adds no latency. With
    // alignment enabled, the shift is computed wide enough that no bit is
    // lost before saturation.
    for (genvar l = 0; l < X_PE; l++) begin : g_lane
        logic [7:0]         lane_byte;
        logic [OUT_LEN-1:0] lane_out;
        assign lane_byte = fifo_head[l*8 +: 8];
`ifdef BIAS_ALIGN_EN
        logic signed [WIDE_W-1:0] lane_wide;
        assign lane_wide = $signed({{(WIDE_W-8){lane_byte[7]}}, lane_byte}) <<< shift_r;
        always_comb begin
            lane_out = lane_wide[OUT_LEN-1:0];
            if (lane_wide > SAT_MAX) begin
                lane_out = SAT_MAX[OUT_LEN-1:0];
            end else if (lane_wide < SAT_MIN) begin
                lane_out = SAT_MIN[OUT_LEN-1:0];
            end
        end
`else
        assign lane_out = {{(OUT_LEN-8){lane_byte[7]}}, lane_byte};
`endif
        assign aligned[l*OUT_LEN +: OUT_LEN] = lane_out;
    end

    assign bias_valid = !fifo_empty;
    assign bias_out   = bias_valid ? aligned : '0;

endmodule

// File: tb/tb_bias_read_control.sv
// tb_bias_read_control
// Self-checking bench for bias_read_control. A behavioural bank memory
// answers the reads. The expected vector stream is derived from the sweep
// rules: every address of a sweep in order, repeated, and each lane taken as
// a signed byte of its bank word. Compile with BIAS_ALIGN_EN to exercise
// the saturating alignment.
module tb_bias_read_control;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         conf = 1'b0;
    logic [23:0]  bias_num = '0;
    logic [23:0]  repeat_num = '0;
    logic [15:0]  bb_st_addr = '0;
    logic [3:0]   bias_shift = '0;
    logic         bb_rd_en;
    logic [15:0]  bb_rd_addr;
    logic [127:0] bb_rd_data = '0;
    logic [255:0] bias_out;
    logic         bias_valid;
    logic         bias_ready = 1'b0;
    logic         done;
    logic         idle;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    bias_read_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .conf       (conf),
        .bias_num   (bias_num),
        .repeat_num (repeat_num),
        .bb_st_addr (bb_st_addr),
        .bias_shift (bias_shift),
        .bb_rd_en   (bb_rd_en),
        .bb_rd_addr (bb_rd_addr),
        .bb_rd_data (bb_rd_data),
        .bias_out   (bias_out),
        .bias_valid (bias_valid),
        .bias_ready (bias_ready),
        .done       (done),
        .idle       (idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Bank memory contents are a hash of the address, with one optional override word.
    logic [31:0]  seed = 32'h1234_5678;
    logic         ovr_en = 1'b0;
    logic [15:0]  ovr_addr = '0;
    logic [127:0] ovr_word = '0;
`ifdef BIAS_ALIGN_EN
    logic [3:0]   cur_shift = '0;
`endif

    function automatic logic [127:0] word_of(input logic [15:0] a);
        logic [127:0] w;
        logic [31:0]  x;
        if (ovr_en && a == ovr_addr) return ovr_word;
        for (int k = 0; k < 4; k++) begin
            x = {a, 16'(k)} ^ seed;
            x = x * 32'h9E3779B1;
            x = x ^ (x >> 15);
            x = x * 32'h85EBCA6B;
            x = x ^ (x >> 13);
            w[k*32 +: 32] = x;
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (bb_rd_en) bb_rd_data <= word_of(bb_rd_addr);
    end

    // Reference lane math: lane l is byte l%8 of bank l/8, read as a signed number.
    function automatic logic [255:0] exp_vec(input logic [127:0] w);
        logic [255:0] r;
        logic [7:0]   b;
        int           v;
        for (int l = 0; l < 16; l++) begin
            b = w[(l / 8) * 64 + (l % 8) * 8 +: 8];
            v = $signed(b);
`ifdef BIAS_ALIGN_EN
            v = v * (1 << cur_shift);
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
`endif
            r[l*16 +: 16] = v[15:0];
        end
        return r;
    endfunction

    // Monitor state, sampled on the falling edge.
    bit           mon_en = 1'b0;
    int           c0 = 0;
    logic [15:0]  rd_q[$];
    int           rd_cyc_q[$];
    logic [255:0] got_q[$];
    int           acc_cyc_q[$];
    int           issued, accepted, max_outst, stall_err, done_cnt, done_cyc, idle_low;
    bit           prev_stall;
    logic [255:0] prev_out;
    int           mk;

    always @(negedge clk) begin
        if (mon_en) begin
            mk = cyc - c0 + 1;
            if (bb_rd_en === 1'b1) begin
                rd_q.push_back(bb_rd_addr);
                rd_cyc_q.push_back(mk);
                issued++;
            end
            if (issued - accepted > max_outst) max_outst = issued - accepted;
            if (prev_stall && (bias_valid !== 1'b1 || bias_out !== prev_out)) stall_err++;
            prev_stall = (bias_valid === 1'b1) && !bias_ready;
            prev_out   = bias_out;
            if (bias_valid === 1'b1 && bias_ready) begin
                got_q.push_back(bias_out);
                acc_cyc_q.push_back(mk);
                accepted++;
            end
            if (done !== 1'b0) begin
                done_cnt++;
                done_cyc = mk;
            end
            if (idle !== 1'b1) idle_low++;
        end
    end

    task automatic clear_mon();
        rd_q.delete(); rd_cyc_q.delete(); got_q.delete(); acc_cyc_q.delete();
        issued = 0; accepted = 0; max_outst = 0; stall_err = 0;
        done_cnt = 0; done_cyc = -1; idle_low = 0; prev_stall = 0; prev_out = '0;
    endtask

    // Results of the last run_config, computed against the reference model.
    logic [255:0] exp_q[$];
    logic [15:0]  exp_addr_q[$];
    int           vec_mis, addr_mis, first_mis;

    // Drives one configuration and follows it until done or a cycle budget
    // runs out. rmode selects ready: 0 = always 1, 1 = 1-0-0-1, 2 = random.
    task automatic run_config(input int n, input int r, input logic [15:0] st,
                              input logic [3:0] sh, input int rmode, input int inject_k);
        int budget;
        exp_q.delete();
        exp_addr_q.delete();
`ifdef BIAS_ALIGN_EN
        cur_shift = sh;
`endif
        for (int rr = 0; rr < r; rr++) begin
            for (int a = 0; a < n; a++) begin
                exp_addr_q.push_back(st + 16'(a));
                exp_q.push_back(exp_vec(word_of(st + 16'(a))));
            end
        end
        clear_mon();
        budget = n * r * 4 + 20;
        @(posedge clk); #1;
        conf = 1'b1; bias_num = 24'(n); repeat_num = 24'(r);
        bb_st_addr = st; bias_shift = sh; bias_ready = 1'b1;
        @(posedge clk); #1;
        c0 = cyc; mon_en = 1'b1; conf = 1'b0;
        bias_num = 24'($urandom); repeat_num = 24'($urandom);
        bb_st_addr = 16'($urandom); bias_shift = 4'($urandom);
        for (int k = 1; k <= budget; k++) begin
            case (rmode)
                0:       bias_ready = 1'b1;
                1:       bias_ready = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
                default: bias_ready = ($urandom % 3) != 0;
            endcase
            if (k == inject_k) conf = 1'b1;
            @(posedge clk); #1;
            conf = 1'b0;
            if (done_cnt > 0) break;
        end
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        bias_ready = 1'b0;
        vec_mis = (got_q.size() != exp_q.size()) ? 1 : 0;
        first_mis = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                vec_mis++;
                if (first_mis < 0) first_mis = i;
            end
        end
        addr_mis = (rd_q.size() != exp_addr_q.size()) ? 1 : 0;
        for (int i = 0; i < rd_q.size() && i < exp_addr_q.size(); i++) begin
            if (rd_q[i] !== exp_addr_q[i]) addr_mis++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bb_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rd_en: got %b want 0", bb_rd_en); end
        tests_run++;
        if (bb_rd_addr !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_rd_addr: got %h want 0", bb_rd_addr); end
        tests_run++;
        if (bias_out !== '0) begin tests_failed++; $display("[TB] FAIL reset_bias_out: got %h want 0", bias_out); end
        tests_run++;
        if (bias_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b want 0", bias_valid); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        tests_run++;
        if (idle !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_idle: got %b want 1", idle); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int bad_cyc;
        run_config(4, 2, 16'h0010, 4'd0, 0, 0);
        tests_run++;
        if (vec_mis != 0) begin tests_failed++; $display("[TB] FAIL basic_vectors: got %0d vectors, %0d bad (first %0d), want 8 exact", got_q.size(), vec_mis, first_mis); end
        tests_run++;
        if (addr_mis != 0) begin tests_failed++; $display("[TB] FAIL basic_addrs: got %0d reads, %0d bad, want 0x10..0x13 twice", rd_q.size(), addr_mis); end
        bad_cyc = (acc_cyc_q.size() != 8) ? 1 : 0;
        for (int i = 0; i < acc_cyc_q.size(); i++) if (acc_cyc_q[i] != 3 + i) bad_cyc++;
        tests_run++;
        if (bad_cyc != 0) begin tests_failed++; $display("[TB] FAIL basic_vector_cycles: %0d off-schedule, first at %0d, want cycles 3..10", bad_cyc, (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : -1); end
        tests_run++;
        if (rd_cyc_q.size() == 0 || rd_cyc_q[0] != 1) begin tests_failed++; $display("[TB] FAIL basic_first_read: got cycle %0d want 1", (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -1); end
        tests_run++;
        if (done_cnt != 1 || done_cyc != 11) begin tests_failed++; $display("[TB] FAIL basic_done: got %0d pulses at cycle %0d, want 1 at 11", done_cnt, done_cyc); end
    endtask

    task automatic test_backpressure();
        run_config(4, 2, 16'h0010, 4'd0, 1, 0);
        tests_run++;
        if (vec_mis != 0) begin tests_failed++; $display("[TB] FAIL bp_vectors: got %0d vectors, %0d bad (first %0d), want 8", got_q.size(), vec_mis, first_mis); end
        tests_run++;
        if (stall_err != 0) begin tests_failed++; $display("[TB] FAIL bp_stable: got %0d unstable stalls, want 0", stall_err); end
        tests_run++;
        if (max_outst > 3) begin tests_failed++; $display("[TB] FAIL bp_outstanding: got %0d, want <= 3", max_outst); end
        tests_run++;
        if (done_cnt != 1 || addr_mis != 0) begin tests_failed++; $display("[TB] FAIL bp_done_addrs: got done %0d addr errs %0d, want 1 and 0", done_cnt, addr_mis); end
    endtask

    task automatic test_lane_sign();
        logic [255:0] v;
        logic [15:0]  want0, want15;
        ovr_word = '0;
        ovr_word[7:0] = 8'h80;
        ovr_word[127:120] = 8'h7F;
        ovr_addr = 16'h0040;
        ovr_en = 1'b1;
        run_config(1, 1, 16'h0040, 4'd9, 0, 0);
        ovr_en = 1'b0;
`ifdef BIAS_ALIGN_EN
        want0 = 16'h8000; want15 = 16'h7FFF;
`else
        want0 = 16'hFF80; want15 = 16'h007F;
`endif
        v = (got_q.size() > 0) ? got_q[0] : 'x;
        tests_run++;
        if (v[15:0] !== want0) begin tests_failed++; $display("[TB] FAIL lane0_sign: got %h want %h", v[15:0], want0); end
        tests_run++;
        if (v[255:240] !== want15) begin tests_failed++; $display("[TB] FAIL lane15_sign: got %h want %h", v[255:240], want15); end
        tests_run++;
        if (vec_mis != 0) begin tests_failed++; $display("[TB] FAIL lane_vector: got %h want %h", v, exp_q[0]); end
    endtask

    task automatic test_zero_config();
        run_config(0, 3, 16'h0020, 4'd0, 0, 0);
        tests_run++;
        if (rd_q.size() != 0) begin tests_failed++; $display("[TB] FAIL zero_num_reads: got %0d reads want 0", rd_q.size()); end
        tests_run++;
        if (done_cnt != 1 || done_cyc != 1) begin tests_failed++; $display("[TB] FAIL zero_num_done: got %0d pulses at cycle %0d, want 1 at 1", done_cnt, done_cyc); end
        tests_run++;
        if (idle_low != 0 || got_q.size() != 0) begin tests_failed++; $display("[TB] FAIL zero_num_idle: got %0d busy cycles %0d vectors, want 0 0", idle_low, got_q.size()); end
        run_config(5, 0, 16'h0020, 4'd0, 0, 0);
        tests_run++;
        if (rd_q.size() != 0 || done_cnt != 1 || done_cyc != 1) begin tests_failed++; $display("[TB] FAIL zero_rep: got %0d reads, done %0d at %0d, want 0, 1 at 1", rd_q.size(), done_cnt, done_cyc); end
    endtask

    task automatic test_addr_wrap();
        logic [15:0] want[3];
        int bad;
        want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000;
        run_config(3, 1, 16'hFFFE, 4'($urandom), 2, 0);
        bad = (rd_q.size() != 3) ? 1 : 0;
        for (int i = 0; i < 3 && i < rd_q.size(); i++) if (rd_q[i] !== want[i]) bad++;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("[TB] FAIL wrap_addrs: got %0d reads, %0d wrong, want FFFE FFFF 0000", rd_q.size(), bad); end
        tests_run++;
        if (vec_mis != 0 || done_cnt != 1) begin tests_failed++; $display("[TB] FAIL wrap_vectors: got %0d bad, done %0d, want 0 and 1", vec_mis, done_cnt); end
    endtask

    task automatic test_conf_ignored();
        run_config(3, 2, 16'h0100, 4'd2, 0, 2);
        tests_run++;
        if (vec_mis != 0 || addr_mis != 0) begin tests_failed++; $display("[TB] FAIL conf_in_run: got %0d vectors (%0d bad), %0d addr errs, want 6 exact", got_q.size(), vec_mis, addr_mis); end
        tests_run++;
        if (done_cnt != 1) begin tests_failed++; $display("[TB] FAIL conf_in_run_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        conf = 1'b1; bias_num = 24'd6; repeat_num = 24'd3; bb_st_addr = 16'h0200; bias_ready = 1'b0;
        @(posedge clk); #1;
        conf = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (bb_rd_en !== 1'b0 || bb_rd_addr !== 16'h0 || bias_out !== '0) begin tests_failed++; $display("[TB] FAIL midrst_read_out: got en %b addr %h out %h, want 0 0 0", bb_rd_en, bb_rd_addr, bias_out); end
        tests_run++;
        if (bias_valid !== 1'b0 || done !== 1'b0 || idle !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_status: got valid %b done %b idle %b, want 0 0 1", bias_valid, done, idle); end
        rst_n = 1'b1;
        bias_ready = 1'b1;
        clear_mon();
        c0 = cyc; mon_en = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        mon_en = 1'b0;
        tests_run++;
        if (issued != 0 || accepted != 0 || done_cnt != 0) begin tests_failed++; $display("[TB] FAIL midrst_quiet: got %0d reads %0d vectors %0d done, want 0 0 0", issued, accepted, done_cnt); end
        run_config(4, 3, 16'h0300, 4'd1, 2, 0);
        tests_run++;
        if (vec_mis != 0 || addr_mis != 0 || done_cnt != 1) begin tests_failed++; $display("[TB] FAIL midrst_rerun: got %0d bad vecs %0d addr errs %0d done, want 0 0 1", vec_mis, addr_mis, done_cnt); end
    endtask

    task automatic test_random();
        int n, r;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 6);
            r = $urandom_range(1, 3);
            seed = $urandom;
            run_config(n, r, 16'($urandom), 4'($urandom), 2, 0);
            tests_run++;
            if (vec_mis != 0 || addr_mis != 0) begin tests_failed++; $display("[TB] FAIL rand%0d_data: got %0d/%0d vectors (%0d bad) %0d addr errs", it, got_q.size(), n * r, vec_mis, addr_mis); end
            tests_run++;
            if (stall_err != 0 || max_outst > 3 || done_cnt != 1) begin tests_failed++; $display("[TB] FAIL rand%0d_flow: got stall errs %0d outst %0d done %0d, want 0 <=3 1", it, stall_err, max_outst, done_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_lane_sign();
        test_zero_config();
        test_addr_wrap();
        test_conf_ignored();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
